// File: rtl/pipeline_front_regs.sv
// rtl/pipeline_front_regs.sv - PC, IF/ID and ID/EX registers with stall, bubble, flush and deadlock watch
module pipeline_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          CTRL_W    = 9,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              holdPC,
  input  logic              holdIF_ID,
  input  logic              muxSelector,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       if_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [31:0]       id_ex_rs_data,
  output logic [31:0]       id_ex_rt_data,
  output logic [31:0]       id_ex_imm,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [CNT_W-1:0]  stall_count,
  output logic              stall_timeout
);

  localparam int            CONS_W = $clog2(MAX_STALL + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_STALL);

  logic [31:0]       pc_plus4;
  logic [CONS_W-1:0] consec;
  logic [CONS_W-1:0] consec_next;

  assign pc_plus4 = pc + 32'd4;

  // Consecutive-hold counter saturates so a long deadlock cannot wrap it back to zero.
  always_comb begin
    consec_next = '0;
    if (holdPC) begin
      consec_next = (consec == CONS_MAX) ? consec : consec + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
    end else begin
      if (!holdPC) begin
        pc <= pc_plus4;
      end
      if (!holdIF_ID) begin
        if_id_instr <= if_instr;
        if_id_pc4   <= pc_plus4;
      end
    end
  end

  // Data fields load unconditionally; only the control bundle is squashed into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_ctrl    <= '0;
      id_ex_rs_data <= '0;
      id_ex_rt_data <= '0;
      id_ex_imm     <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
    end else begin
      id_ex_ctrl    <= (branch_taken || muxSelector) ? '0 : id_ctrl;
      id_ex_rs_data <= id_rs_data;
      id_ex_rt_data <= id_rt_data;
      id_ex_imm     <= id_imm;
      id_ex_rs      <= id_rs;
      id_ex_rt      <= id_rt;
      id_ex_rd      <= id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count   <= '0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      consec <= consec_next;
      if (holdPC && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (holdPC && (consec_next == CONS_MAX)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule
